// File: rtl/dyt_decode_stage_pkg.sv
// Shared types for the decode stage: RV32I opcodes, ALU operation codes,
// immediate formats, the packed control bundle and small decode helpers.
package dyt_decode_stage_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // alu_src bit 0 selects the immediate as operand B, bit 1 selects the PC as operand A
    localparam logic [1:0] ALU_SRC_REGS   = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM    = 2'b01;
    localparam logic [1:0] ALU_SRC_PC_IMM = 2'b11;

    // Writeback source: ALU result, load data, or PC+4 for jumps
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_t;

    // bne marks branches whose comparison result is inverted (bne, bge, bgeu)
    typedef struct packed {
        logic       halt;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic [1:0] mem_to_reg;
        alu_op_t    alu_op;
        logic [1:0] alu_src;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       jal;
        logic       illegal;
    } decode_ctrl_t;

    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/dyt_decode_comb.sv
// Purely combinational RV32I decoder: instruction word to control bundle,
// register indices, immediate and source-usage flags. Unused fields read 0.
module dyt_decode_comb
    import dyt_decode_stage_pkg::*;
#(
    parameter int                WORD_W     = 32,
    parameter int                REG_AW     = 5,
    parameter logic [WORD_W-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic [WORD_W-1:0] instr,
    output decode_ctrl_t      ctrl,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [WORD_W-1:0] imm,
    output logic              uses_rs1,
    output logic              uses_rs2
);

    imm_fmt_t   fmt;
    logic       has_rd;
    logic [2:0] funct3;

    assign funct3 = instr[14:12];

    // Classify the opcode; halt is checked first since its encoding is otherwise illegal
    always_comb begin
        ctrl     = '0;
        fmt      = FMT_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_rd   = 1'b0;
        if (instr == HALT_INSTR) begin
            ctrl.halt = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_LUI: begin
                    fmt = FMT_U; has_rd = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_PASS_B;
                    ctrl.alu_src   = ALU_SRC_IMM;
                end
                OPC_AUIPC: begin
                    fmt = FMT_U; has_rd = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = ALU_SRC_PC_IMM;
                end
                OPC_JAL: begin
                    fmt = FMT_J; has_rd = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.jump       = 1'b1;
                    ctrl.jal        = 1'b1;
                    ctrl.alu_src    = ALU_SRC_PC_IMM;
                    ctrl.mem_to_reg = WB_PC4;
                end
                OPC_JALR: begin
                    fmt = FMT_I; has_rd = 1'b1; uses_rs1 = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.jump       = 1'b1;
                    ctrl.alu_src    = ALU_SRC_IMM;
                    ctrl.mem_to_reg = WB_PC4;
                end
                OPC_BRANCH: begin
                    fmt = FMT_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                    ctrl.branch = 1'b1;
                    ctrl.bne    = funct3[0];
                    ctrl.alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                end
                OPC_LOAD: begin
                    fmt = FMT_I; has_rd = 1'b1; uses_rs1 = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_size   = funct3[1:0];
                    ctrl.mem_to_reg = WB_MEM;
                    ctrl.alu_src    = ALU_SRC_IMM;
                end
                OPC_STORE: begin
                    fmt = FMT_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.mem_size  = funct3[1:0];
                    ctrl.alu_src   = ALU_SRC_IMM;
                end
                OPC_OP_IMM: begin
                    fmt = FMT_I; has_rd = 1'b1; uses_rs1 = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
                    ctrl.alu_src   = ALU_SRC_IMM;
                end
                OPC_OP: begin
                    fmt = FMT_R; has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_from_funct3(funct3, instr[30]);
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                    fmt = FMT_NONE;
                end
                default: begin
                    ctrl.illegal = 1'b1;
                end
            endcase
        end

        rd  = has_rd   ? instr[11:7]  : '0;
        rs1 = uses_rs1 ? instr[19:15] : '0;
        rs2 = uses_rs2 ? instr[24:20] : '0;
        imm = imm_extract(instr, fmt);
        if (rd == '0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/dyt_decode_stage.sv
// Registered decode stage: output bundle register with valid/ready handshake,
// load-use scoreboard, hazard stalls, flush, sticky halt and stall counter.
module dyt_decode_stage
    import dyt_decode_stage_pkg::*;
#(
    parameter int                WORD_W     = 32,
    parameter int                REG_AW     = 5,
    parameter int                LOAD_LAT   = 2,
    parameter int                CNT_W      = 16,
    parameter logic [WORD_W-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [WORD_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output decode_ctrl_t      out_ctrl,
    output logic [WORD_W-1:0] out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [WORD_W-1:0] out_imm,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SB_CW = $clog2(LOAD_LAT + 1);

    decode_ctrl_t      dec_ctrl;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [WORD_W-1:0] dec_imm;
    logic              dec_uses_rs1, dec_uses_rs2;

    logic              out_valid_q, out_valid_d;
    decode_ctrl_t      out_ctrl_q, out_ctrl_d;
    logic [WORD_W-1:0] out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [REG_AW-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_rd_q, out_rd_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              sb_valid_q [LOAD_LAT];
    logic              sb_valid_d [LOAD_LAT];
    logic [REG_AW-1:0] sb_rd_q    [LOAD_LAT];
    logic [REG_AW-1:0] sb_rd_d    [LOAD_LAT];
    logic [SB_CW-1:0]  sb_cnt_q   [LOAD_LAT];
    logic [SB_CW-1:0]  sb_cnt_d   [LOAD_LAT];

    logic hit_rs1, hit_rs2, hazard, accept, out_fire, push, pushed;

    dyt_decode_comb #(
        .WORD_W     (WORD_W),
        .REG_AW     (REG_AW),
        .HALT_INSTR (HALT_INSTR)
    ) u_decode (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    // Load-use hazard: a used nonzero source matches a pending load or the load sitting in the output
    always_comb begin
        hit_rs1 = out_valid_q && out_ctrl_q.mem_read && (out_rd_q == dec_rs1);
        hit_rs2 = out_valid_q && out_ctrl_q.mem_read && (out_rd_q == dec_rs2);
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_valid_q[i] && (sb_rd_q[i] == dec_rs1)) hit_rs1 = 1'b1;
            if (sb_valid_q[i] && (sb_rd_q[i] == dec_rs2)) hit_rs2 = 1'b1;
        end
        hazard = in_valid && ((dec_uses_rs1 && (dec_rs1 != '0) && hit_rs1) ||
                              (dec_uses_rs2 && (dec_rs2 != '0) && hit_rs2));
    end

    assign in_ready = !halted_q && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready && !flush;
    assign push     = out_fire && out_ctrl_q.mem_read && (out_rd_q != '0);

    // Output register next state: flush kills, acceptance loads, consumption empties
    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = dec_ctrl;
            out_pc_d    = in_pc;
            out_imm_d   = dec_imm;
            out_rs1_d   = dec_rs1;
            out_rs2_d   = dec_rs2;
            out_rd_d    = dec_rd;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        halted_d    = halted_q || (accept && dec_ctrl.halt);
        stall_cnt_d = (hazard && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // Scoreboard ageing, then record a departing load into the first free slot
    always_comb begin
        pushed = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            sb_valid_d[i] = sb_valid_q[i];
            sb_rd_d[i]    = sb_rd_q[i];
            sb_cnt_d[i]   = sb_cnt_q[i];
            if (sb_valid_q[i]) begin
                if (sb_cnt_q[i] == SB_CW'(1)) begin
                    sb_valid_d[i] = 1'b0;
                    sb_cnt_d[i]   = '0;
                end else begin
                    sb_cnt_d[i] = sb_cnt_q[i] - 1'b1;
                end
            end
        end
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (push && !pushed && !sb_valid_d[i]) begin
                sb_valid_d[i] = 1'b1;
                sb_rd_d[i]    = out_rd_q;
                sb_cnt_d[i]   = SB_CW'(LOAD_LAT);
                pushed        = 1'b1;
            end
        end
    end

    // All stage state, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_valid_q[i] <= 1'b0;
                sb_rd_q[i]    <= '0;
                sb_cnt_q[i]   <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_pc_q    <= out_pc_d;
            out_imm_q   <= out_imm_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_q    <= out_rd_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_valid_q[i] <= sb_valid_d[i];
                sb_rd_q[i]    <= sb_rd_d[i];
                sb_cnt_q[i]   <= sb_cnt_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_pc    = out_pc_q;
    assign out_imm   = out_imm_q;
    assign out_rs1   = out_rs1_q;
    assign out_rs2   = out_rs2_q;
    assign out_rd    = out_rd_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dyt_decode_stage.sv
// Directed bench for the decode stage: pipelined ADDI, load-use stall,
// backpressure hold, flush, illegal/x0 decode, and sticky halt with async reset.
module tb_dyt_decode_stage;
    import dyt_decode_stage_pkg::*;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         in_valid, in_ready, flush, out_valid, out_ready, halted;
    logic [31:0]  in_instr, in_pc, out_pc, out_imm;
    logic [4:0]   out_rs1, out_rs2, out_rd;
    logic [15:0]  stall_cnt;
    decode_ctrl_t out_ctrl;

    int vecCount = 0;
    int errCount = 0;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] I_ADDI_X2_X1  = 32'h0010_8113;
    localparam logic [31:0] I_LW_X3       = 32'h0002_2183;
    localparam logic [31:0] I_ADD_X5      = 32'h0031_82B3;
    localparam logic [31:0] I_BEQ_M8      = 32'hFE20_8CE3;
    localparam logic [31:0] I_ILLEGAL     = 32'h0000_0000;
    localparam logic [31:0] I_ADDI_X0     = 32'h0010_8013;
    localparam logic [31:0] I_HALT        = 32'hFFFF_FFFF;

    decode_ctrl_t expAddi, expAddiX0, expLw, expAdd, expBeq, expIll, expHalt;

    dyt_decode_stage dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_rd    (out_rd),
        .out_imm   (out_imm),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        expAddi = '0;   expAddi.reg_write = 1'b1; expAddi.alu_op = ALU_ADD; expAddi.alu_src = 2'b01;
        expAddiX0 = '0; expAddiX0.alu_op = ALU_ADD; expAddiX0.alu_src = 2'b01;
        expLw = '0;     expLw.reg_write = 1'b1; expLw.mem_read = 1'b1; expLw.mem_size = 2'b10;
                        expLw.mem_to_reg = 2'b01; expLw.alu_op = ALU_ADD; expLw.alu_src = 2'b01;
        expAdd = '0;    expAdd.reg_write = 1'b1; expAdd.alu_op = ALU_ADD;
        expBeq = '0;    expBeq.branch = 1'b1; expBeq.alu_op = ALU_SUB;
        expIll = '0;    expIll.illegal = 1'b1;
        expHalt = '0;   expHalt.halt = 1'b1;

        nRST = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_halted",    32'(halted),    32'h0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("rst_out_ctrl",  32'(out_ctrl),  32'h0);
        checkOutput("rst_out_imm",   out_imm,        32'h0);
        nextCycle();
        nRST = 1'b1;
        nextCycle();

        // Back-to-back ADDI with no stall
        applyStimulus(1'b1, I_ADDI_X1_5, 32'h100, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t1_in_ready_a", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X2_X1, 32'h104, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t1_valid_a", 32'(out_valid), 32'h1);
        checkOutput("t1_imm_a",   out_imm,        32'h5);
        checkOutput("t1_rd_a",    32'(out_rd),    32'h1);
        checkOutput("t1_ctrl_a",  32'(out_ctrl),  32'(expAddi));
        checkOutput("t1_in_ready_b", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t1_valid_b", 32'(out_valid), 32'h1);
        checkOutput("t1_imm_b",   out_imm,        32'h1);
        checkOutput("t1_rs1_b",   32'(out_rs1),   32'h1);
        checkOutput("t1_rd_b",    32'(out_rd),    32'h2);
        checkOutput("t1_pc_b",    out_pc,         32'h104);
        checkOutput("t1_stall",   32'(stall_cnt), 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("t1_drained", 32'(out_valid), 32'h0);
        nextCycle();

        // Load-use: ADD blocked while LW sits in the output and for 2 cycles after it leaves
        applyStimulus(1'b1, I_LW_X3, 32'h200, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, I_ADD_X5, 32'h204, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t2_lw_ctrl",  32'(out_ctrl), 32'(expLw));
        checkOutput("t2_lw_rs1",   32'(out_rs1),  32'h4);
        checkOutput("t2_stall_c1", 32'(in_ready), 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("t2_lw_gone",  32'(out_valid), 32'h0);
        checkOutput("t2_stall_c2", 32'(in_ready),  32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("t2_stall_c3", 32'(in_ready), 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("t2_release",  32'(in_ready),  32'h1);
        checkOutput("t2_stall_cnt", 32'(stall_cnt), 32'h3);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t2_add_valid", 32'(out_valid), 32'h1);
        checkOutput("t2_add_ctrl",  32'(out_ctrl),  32'(expAdd));
        checkOutput("t2_add_regs",  32'({out_rs1, out_rs2, out_rd}), 32'({5'd3, 5'd3, 5'd5}));
        nextCycle();

        // Backpressure: BEQ held stable for 3 cycles, then drains
        applyStimulus(1'b1, I_BEQ_M8, 32'h300, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X1_5, 32'h304, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("t3_hold_valid", 32'(out_valid), 32'h1);
            checkOutput("t3_hold_imm",   out_imm,        32'hFFFF_FFF8);
            checkOutput("t3_hold_pc",    out_pc,         32'h300);
            checkOutput("t3_hold_ctrl",  32'(out_ctrl),  32'(expBeq));
            checkOutput("t3_in_ready",   32'(in_ready),  32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t3_drain_imm", out_imm, 32'hFFFF_FFF8);
        checkOutput("t3_drain_rs",  32'({out_rs1, out_rs2, out_rd}), 32'({5'd1, 5'd2, 5'd0}));
        nextCycle();
        @(negedge CLK);
        checkOutput("t3_empty", 32'(out_valid), 32'h0);
        nextCycle();

        // Flush beats out_ready; next instruction accepted the cycle after
        applyStimulus(1'b1, I_ADDI_X1_5, 32'h400, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X2_X1, 32'h404, 1'b1, 1'b1);
        @(negedge CLK);
        checkOutput("t4_pre_valid", 32'(out_valid), 32'h1);
        checkOutput("t4_flush_rdy", 32'(in_ready),  32'h0);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X2_X1, 32'h404, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t4_killed",    32'(out_valid), 32'h0);
        checkOutput("t4_post_rdy",  32'(in_ready),  32'h1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t4_next_valid", 32'(out_valid), 32'h1);
        checkOutput("t4_next_pc",    out_pc,         32'h404);
        nextCycle();

        // Illegal opcode, then ADDI to x0
        applyStimulus(1'b1, I_ILLEGAL, 32'h500, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X0, 32'h504, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t6_ill_ctrl", 32'(out_ctrl), 32'(expIll));
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t6_x0_ctrl", 32'(out_ctrl), 32'(expAddiX0));
        checkOutput("t6_x0_rd",   32'(out_rd),   32'h0);
        checkOutput("t6_x0_imm",  out_imm,       32'h1);
        nextCycle();

        // Halt: bundle goes out, halted sticks through flush, async reset clears it
        applyStimulus(1'b1, I_HALT, 32'h600, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t5_halt_rdy", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b1, I_ADDI_X1_5, 32'h604, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("t5_halt_valid", 32'(out_valid), 32'h1);
        checkOutput("t5_halt_ctrl",  32'(out_ctrl),  32'(expHalt));
        checkOutput("t5_halted",     32'(halted),    32'h1);
        nextCycle();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, I_ADDI_X1_5, 32'h604, 1'b1, (i == 4));
            @(negedge CLK);
            checkOutput("t5_blocked", 32'(in_ready), 32'h0);
            nextCycle();
        end
        @(negedge CLK);
        checkOutput("t5_still_halted", 32'(halted), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("t5_rst_halted", 32'(halted),    32'h0);
        checkOutput("t5_rst_valid",  32'(out_valid), 32'h0);
        checkOutput("t5_rst_stall",  32'(stall_cnt), 32'h0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
